// File: rtl/rr_arbiter_n_pkg.sv
// Shared constants and helpers for the N-port round-robin arbiter.
package rr_arb_pkg;

  localparam int RR_MAX_PORTS       = 16;
  localparam int RR_CNT_W           = 4;
  localparam int RR_DEFAULT_QUANTUM = 4;

  // Select width for n ports, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Arbiter <-> FIFO bank bundle: requests/backpressure in, pop strobes and mux select out.
interface rr_arbiter_n_if #(parameter int N_PORTS = 4);
  import rr_arb_pkg::*;

  localparam int SEL_W = sel_w(N_PORTS);

  logic [N_PORTS-1:0] request;
  logic               pause;
  logic [N_PORTS-1:0] pop;
  logic [SEL_W-1:0]   port_sel;
  logic               grant_valid;
  logic               idle;

  modport master (
    input  request, pause,
    output pop, port_sel, grant_valid, idle
  );

  modport slave (
    output request, pause,
    input  pop, port_sel, grant_valid, idle
  );

endinterface

// File: rtl/rr_arbiter_n_pick.sv
// Combinational rotating-priority encoder: first set request bit at or after i_start, with wrap.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter  int N_PORTS = 4,
  localparam int SEL_W   = sel_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] i_request,
  input  logic [SEL_W-1:0]   i_start,
  output logic [SEL_W-1:0]   o_winner,
  output logic               o_hit
);

  logic [2*N_PORTS-1:0] w_dbl;
  logic [N_PORTS-1:0]   w_rot;
  logic [SEL_W-1:0]     w_off;
  logic [SEL_W:0]       w_sum;

  // Rotate so bit 0 is the start port; the lowest set bit is then the winner's offset.
  assign w_dbl = {i_request, i_request};
  assign w_rot = N_PORTS'(w_dbl >> i_start);

  always_comb begin
    w_off = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
  end

  assign w_sum    = {1'b0, i_start} + {1'b0, w_off};
  assign o_winner = (w_sum >= (SEL_W+1)'(N_PORTS)) ? SEL_W'(w_sum - (SEL_W+1)'(N_PORTS))
                                                   : w_sum[SEL_W-1:0];
  assign o_hit    = |i_request;

endmodule

// File: rtl/rr_arbiter_n.sv
// N-port round-robin arbiter with registered one-hot pop, mux select and pause backpressure.
// Define RR_BURST_EN to let a winner hold the path for up to QUANTUM consecutive pops.
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter  int N_PORTS = 4,
  parameter  int QUANTUM = RR_DEFAULT_QUANTUM,
  localparam int SEL_W   = sel_w(N_PORTS)
) (
  input logic             clk,
  input logic             reset_L,
  rr_arbiter_n_if.master  bus
);

  if (N_PORTS < 2 || N_PORTS > RR_MAX_PORTS || QUANTUM < 1 || QUANTUM > (1 << RR_CNT_W) - 1)
  begin : g_bad_cfg
    $error("rr_arbiter_n: N_PORTS or QUANTUM out of range");
  end

  logic [N_PORTS-1:0] r_pop,  w_pop_next;
  logic [SEL_W-1:0]   r_sel,  w_sel_next;
  logic               r_gv,   w_gv_next;
  logic               r_idle;
  logic [SEL_W-1:0]   r_ptr,  w_ptr_next;
  logic [SEL_W-1:0]   w_start;
  logic [SEL_W-1:0]   w_win;
  logic               w_hit;

`ifdef RR_BURST_EN
  logic [RR_CNT_W-1:0] r_burst_cnt, w_cnt_next;
  logic                r_hold,      w_hold_next;
`endif

  // Scan begins one past the last winner so the previous holder ranks last.
  assign w_start = (r_ptr == SEL_W'(N_PORTS - 1)) ? '0 : r_ptr + 1'b1;

  rr_pick #(.N_PORTS(N_PORTS)) u_pick (
    .i_request (bus.request),
    .i_start   (w_start),
    .o_winner  (w_win),
    .o_hit     (w_hit)
  );

  always_comb begin
    w_pop_next = '0;
    w_gv_next  = 1'b0;
    w_sel_next = r_sel;
    w_ptr_next = r_ptr;
`ifdef RR_BURST_EN
    w_cnt_next  = r_burst_cnt;
    w_hold_next = r_hold;
    if (!bus.pause) begin
      if (r_hold && bus.request[r_ptr] && r_burst_cnt < RR_CNT_W'(QUANTUM - 1)) begin
        w_pop_next = N_PORTS'(1) << r_ptr;
        w_gv_next  = 1'b1;
        w_sel_next = r_ptr;
        w_cnt_next = r_burst_cnt + 1'b1;
      end else if (w_hit) begin
        w_pop_next  = N_PORTS'(1) << w_win;
        w_gv_next   = 1'b1;
        w_sel_next  = w_win;
        w_ptr_next  = w_win;
        w_cnt_next  = '0;
        w_hold_next = 1'b1;
      end else begin
        w_cnt_next  = '0;
        w_hold_next = 1'b0;
      end
    end
`else
    if (!bus.pause && w_hit) begin
      w_pop_next = N_PORTS'(1) << w_win;
      w_gv_next  = 1'b1;
      w_sel_next = w_win;
      w_ptr_next = w_win;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset_L) begin
      r_pop       <= '0;
      r_gv        <= 1'b0;
      r_sel       <= '0;
      r_idle      <= 1'b1;
      r_ptr       <= SEL_W'(N_PORTS - 1);
`ifdef RR_BURST_EN
      r_burst_cnt <= '0;
      r_hold      <= 1'b0;
`endif
    end else begin
      r_pop       <= w_pop_next;
      r_gv        <= w_gv_next;
      r_sel       <= w_sel_next;
      r_idle      <= ~|bus.request;
      r_ptr       <= w_ptr_next;
`ifdef RR_BURST_EN
      r_burst_cnt <= w_cnt_next;
      r_hold      <= w_hold_next;
`endif
    end
  end

  assign bus.pop         = r_pop;
  assign bus.port_sel    = r_sel;
  assign bus.grant_valid = r_gv;
  assign bus.idle        = r_idle;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed scoreboard bench for rr_arbiter_n: a 4-port instance (QUANTUM 3) and a 3-port instance.
module tb_rr_arbiter_n;

  typedef struct {
    int          due;
    bit          which;
    logic [3:0]  pop;
    logic        gv;
    logic [1:0]  sel;
    logic        idle;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rst3 = 1'b1;
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t e;
  logic [3:0] a_pop;
  logic       a_gv;
  logic [1:0] a_sel;
  logic       a_idle;

  rr_arbiter_n_if #(.N_PORTS(4)) bus4 ();
  rr_arbiter_n_if #(.N_PORTS(3)) bus3 ();

  rr_arbiter_n #(.N_PORTS(4), .QUANTUM(3)) u_dut4 (
    .clk     (clk),
    .reset_L (rst4),
    .bus     (bus4.master)
  );

  rr_arbiter_n #(.N_PORTS(3), .QUANTUM(1)) u_dut3 (
    .clk     (clk),
    .reset_L (rst3),
    .bus     (bus3.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare every expectation whose target edge has passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= edge_cnt) begin
      e = q.pop_front();
      if (e.which) begin
        a_pop  = {1'b0, bus3.pop};
        a_gv   = bus3.grant_valid;
        a_sel  = bus3.port_sel;
        a_idle = bus3.idle;
      end else begin
        a_pop  = bus4.pop;
        a_gv   = bus4.grant_valid;
        a_sel  = bus4.port_sel;
        a_idle = bus4.idle;
      end
      n_cmp++;
      if (a_pop !== e.pop || a_gv !== e.gv || a_sel !== e.sel || a_idle !== e.idle) begin
        n_bad++;
        $display("FAIL edge %0d %s: got pop=%b gv=%b sel=%0d idle=%b, want pop=%b gv=%b sel=%0d idle=%b",
                 e.due, e.name, a_pop, a_gv, a_sel, a_idle, e.pop, e.gv, e.sel, e.idle);
      end else begin
        $display("edge %0d %s: pop=%b gv=%b sel=%0d idle=%b ok",
                 e.due, e.name, a_pop, a_gv, a_sel, a_idle);
      end
    end
  end

  task automatic step(input bit which, input bit rst, input logic [3:0] req, input bit pse,
                      input logic [3:0] epop, input bit egv, input logic [1:0] esel,
                      input bit eidle, input string name);
    exp_t x;
    if (which) begin
      rst3         = rst;
      bus3.request = req[2:0];
    end else begin
      rst4         = rst;
      bus4.request = req;
      bus4.pause   = pse;
    end
    x.due   = edge_cnt + 1;
    x.which = which;
    x.pop   = epop;
    x.gv    = egv;
    x.sel   = esel;
    x.idle  = eidle;
    x.name  = name;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus4.request = '0;
    bus4.pause   = 1'b0;
    bus3.request = '0;
    bus3.pause   = 1'b0;

    step(0, 1, 4'b0000, 0, 4'b0000, 0, 2'd0, 1, "reset");
    step(0, 1, 4'b0000, 0, 4'b0000, 0, 2'd0, 1, "reset");
`ifdef RR_BURST_EN
    step(0, 0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "burst0");
    step(0, 0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "burst0");
    step(0, 0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "burst0");
    step(0, 0, 4'b0011, 0, 4'b0010, 1, 2'd1, 0, "burst1");
    step(0, 0, 4'b0011, 0, 4'b0010, 1, 2'd1, 0, "burst1");
    step(0, 0, 4'b0011, 0, 4'b0010, 1, 2'd1, 0, "burst1");
    step(0, 0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "burst0");
    step(0, 0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "burst0");
    step(0, 0, 4'b0010, 0, 4'b0010, 1, 2'd1, 0, "holder_drop");
    step(0, 0, 4'b0011, 0, 4'b0010, 1, 2'd1, 0, "cnt_restart");
    step(0, 0, 4'b0011, 0, 4'b0010, 1, 2'd1, 0, "cnt_restart");
    step(0, 0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "rotate");
    step(0, 1, 4'b0011, 0, 4'b0000, 0, 2'd0, 1, "reset");
    step(0, 0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "pre_pause");
    step(0, 0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "pre_pause");
    step(0, 0, 4'b0011, 1, 4'b0000, 0, 2'd0, 0, "paused");
    step(0, 0, 4'b0011, 1, 4'b0000, 0, 2'd0, 0, "paused");
    step(0, 0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "resume");
    step(0, 0, 4'b0011, 0, 4'b0010, 1, 2'd1, 0, "after_burst");
    step(0, 0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0, "burst2");
    step(0, 0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0, "burst2");
    step(0, 1, 4'b0100, 0, 4'b0000, 0, 2'd0, 1, "reset_mid");
    step(0, 0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0, "post_reset");
    step(0, 0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0, "post_reset");
    step(0, 0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0, "post_reset");
    step(0, 0, 4'b1111, 0, 4'b0010, 1, 2'd1, 0, "post_reset");
    step(0, 0, 4'b0000, 0, 4'b0000, 0, 2'd1, 1, "no_req");
`else
    step(0, 0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0, "all_req");
    step(0, 0, 4'b1111, 0, 4'b0010, 1, 2'd1, 0, "all_req");
    step(0, 0, 4'b1111, 0, 4'b0100, 1, 2'd2, 0, "all_req");
    step(0, 0, 4'b1111, 0, 4'b1000, 1, 2'd3, 0, "all_req");
    step(0, 0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0, "all_req");
    step(0, 1, 4'b1111, 0, 4'b0000, 0, 2'd0, 1, "reset");
    step(0, 0, 4'b1010, 0, 4'b0010, 1, 2'd1, 0, "req1010");
    step(0, 0, 4'b1010, 0, 4'b1000, 1, 2'd3, 0, "req1010");
    step(0, 0, 4'b1010, 0, 4'b0010, 1, 2'd1, 0, "req1010");
    step(0, 0, 4'b1010, 0, 4'b1000, 1, 2'd3, 0, "req1010");
    step(0, 0, 4'b1000, 0, 4'b1000, 1, 2'd3, 0, "sole_ptr");
    step(0, 0, 4'b1000, 0, 4'b1000, 1, 2'd3, 0, "sole_ptr");
    step(0, 0, 4'b1000, 0, 4'b1000, 1, 2'd3, 0, "sole_ptr");
    step(0, 0, 4'b0000, 0, 4'b0000, 0, 2'd3, 1, "no_req");
    step(0, 0, 4'b0000, 0, 4'b0000, 0, 2'd3, 1, "no_req");
    step(0, 0, 4'b1111, 1, 4'b0000, 0, 2'd3, 0, "pause_on_req");
    step(0, 0, 4'b1111, 1, 4'b0000, 0, 2'd3, 0, "paused");
    step(0, 0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0, "resume");
    step(0, 0, 4'b1111, 0, 4'b0010, 1, 2'd1, 0, "resume");
    step(0, 0, 4'b1111, 1, 4'b0000, 0, 2'd1, 0, "paused");
    step(0, 0, 4'b1111, 0, 4'b0100, 1, 2'd2, 0, "resume");
    step(0, 0, 4'b0101, 0, 4'b0001, 1, 2'd0, 0, "wrap_skip");
    step(0, 0, 4'b0101, 0, 4'b0100, 1, 2'd2, 0, "wrap_skip");
    step(0, 0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0, "port2");
    step(0, 1, 4'b0100, 0, 4'b0000, 0, 2'd0, 1, "reset_mid");
    step(0, 0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0, "post_reset");
    step(0, 0, 4'b1111, 0, 4'b0010, 1, 2'd1, 0, "post_reset");
`endif
    step(0, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 1, "reset");
    q.pop_back();

    step(1, 1, 4'b0000, 0, 4'b0000, 0, 2'd0, 1, "n3_reset");
    step(1, 0, 4'b0111, 0, 4'b0001, 1, 2'd0, 0, "n3_rr");
    step(1, 0, 4'b0111, 0, 4'b0010, 1, 2'd1, 0, "n3_rr");
    step(1, 0, 4'b0111, 0, 4'b0100, 1, 2'd2, 0, "n3_rr");
    step(1, 0, 4'b0111, 0, 4'b0001, 1, 2'd0, 0, "n3_wrap");
    step(1, 0, 4'b0111, 0, 4'b0010, 1, 2'd1, 0, "n3_wrap");
    step(1, 0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0, "n3_top");
    step(1, 0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0, "n3_top");

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
